// File: rtl/gnome_sort_engine_kv.sv
// Batch buffer that gnome-sorts stored words by their key field and then
// streams the sorted batch out on an Avalon-ST source with backpressure.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_LOAD     | accepting words into the buffer, waiting for run_i
// S_SORT_RD  | reading the pair (i-1, i)
// S_SORT_CMP | comparing the pair, writing it back swapped if out of order
// S_DRAIN    | streaming the buffer out from address 0 upward
// S_DONE     | batch finished; only clear_i or rst_i leave this state
module gnome_sort_engine_kv #(
    parameter int AWIDTH     = 5,
    parameter int DWIDTH     = 16,
    parameter int KWIDTH     = 8,
    parameter int SIGNED_KEY = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              run_i,
    input  logic              desc_i,
    input  logic              wr_req_i,
    input  logic [DWIDTH-1:0] wr_data_i,
    output logic              wr_ready_o,
    output logic              busy_o,
    output logic [AWIDTH:0]   count_o,
    output logic              overflow_o,
    input  logic              out_ready_i,
    output logic [DWIDTH-1:0] out_data_o,
    output logic              out_valid_o,
    output logic              out_sop_o,
    output logic              out_eop_o
);

    localparam logic [AWIDTH:0] N_MAX = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0] ONE   = (AWIDTH+1)'(1);
    localparam logic [AWIDTH:0] TWO   = (AWIDTH+1)'(2);

    typedef enum logic [2:0] {S_LOAD, S_SORT_RD, S_SORT_CMP, S_DRAIN, S_DONE} state_t;

    state_t state_q, state_d;

    logic [DWIDTH-1:0] mem [2**AWIDTH];
    logic [DWIDTH-1:0] rd_a_q, rd_b_q, wd_a, wd_b;
    logic [AWIDTH-1:0] ra, rb, wa, wb;
    logic              we_a, we_b;

    logic [AWIDTH:0]   cnt_q, i_q, j_q, i_d, j_d, i_m1;
    logic              ovf_q, desc_q;
    logic [KWIDTH-1:0] key_a, key_b;
    logic              swap;

    logic [AWIDTH:0]   rd_ptr_q, pend_idx_q;
    logic              pend_q, ov_q, sv_q, pop, issue, arr_sop, arr_eop;
    logic [DWIDTH-1:0] od_q, sd_q;
    logic              osop_q, oeop_q, ssop_q, seop_q;
    logic [1:0]        occ;

    // Two-port RAM: synchronous reads on both ports, writes on both ports.
    always_ff @(posedge clk_i) begin
        if (we_a) mem[wa] <= wd_a;
        if (we_b) mem[wb] <= wd_b;
        rd_a_q <= mem[ra];
        rd_b_q <= mem[rb];
    end

    // Key compare for the pair just read; signed keys are biased so an
    // unsigned compare orders them as two's complement.
    always_comb begin
        key_a = rd_a_q[DWIDTH-1 -: KWIDTH];
        key_b = rd_b_q[DWIDTH-1 -: KWIDTH];
        if (SIGNED_KEY != 0) begin
            key_a[KWIDTH-1] = ~key_a[KWIDTH-1];
            key_b[KWIDTH-1] = ~key_b[KWIDTH-1];
        end
        swap = desc_q ? (key_a < key_b) : (key_a > key_b);
        i_m1 = i_q - ONE;
        i_d  = j_q;
        j_d  = j_q + ONE;
        if (swap && i_m1 != '0) begin
            i_d = i_m1;
            j_d = j_q;
        end
    end

    // RAM port steering: loader and swap writes, sort pair and drain reads.
    always_comb begin
        we_a = 1'b0;
        we_b = 1'b0;
        wa   = cnt_q[AWIDTH-1:0];
        wd_a = wr_data_i;
        wb   = i_q[AWIDTH-1:0];
        wd_b = rd_a_q;
        ra   = (state_q == S_DRAIN) ? rd_ptr_q[AWIDTH-1:0] : i_m1[AWIDTH-1:0];
        rb   = i_q[AWIDTH-1:0];
        if (state_q == S_LOAD) begin
            we_a = wr_req_i && !run_i && !clear_i && (cnt_q != N_MAX);
        end else if (state_q == S_SORT_CMP && swap && !clear_i) begin
            we_a = 1'b1;
            wa   = i_m1[AWIDTH-1:0];
            wd_a = rd_b_q;
            we_b = 1'b1;
        end
    end

    // Drain read-ahead: a read is issued only when the output and skid
    // registers are guaranteed room for it, which keeps one beat per cycle.
    always_comb begin
        pop     = ov_q && out_ready_i;
        occ     = 2'(ov_q) + 2'(sv_q) + 2'(pend_q) - 2'(pop);
        issue   = (rd_ptr_q < cnt_q) && (occ < 2'd2);
        arr_sop = (pend_idx_q == '0);
        arr_eop = (pend_idx_q == cnt_q - ONE);
    end

    // Next-state selection; clear_i wins over everything but reset.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = S_LOAD;
        end else begin
            case (state_q)
                S_LOAD: if (run_i) begin
                    if (cnt_q >= TWO)      state_d = S_SORT_RD;
                    else if (cnt_q == ONE) state_d = S_DRAIN;
                    else                   state_d = S_DONE;
                end
                S_SORT_RD:  state_d = S_SORT_CMP;
                S_SORT_CMP: state_d = (i_d == cnt_q) ? S_DRAIN : S_SORT_RD;
                S_DRAIN:    if (pop && oeop_q) state_d = S_DONE;
                default:    state_d = state_q;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_LOAD;
        else       state_q <= state_d;
    end

    // Batch count, overflow flag, direction and sort pointers.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            desc_q <= 1'b0;
            i_q    <= ONE;
            j_q    <= TWO;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (run_i) begin
                        desc_q <= desc_i;
                        i_q    <= ONE;
                        j_q    <= TWO;
                    end else if (wr_req_i) begin
                        if (cnt_q != N_MAX) cnt_q <= cnt_q + ONE;
                        else                ovf_q <= 1'b1;
                    end
                end
                S_SORT_CMP: begin
                    i_q <= i_d;
                    j_q <= j_d;
                end
                default: ;
            endcase
        end
    end

    // Output register plus one-entry skid; everything idles outside DRAIN.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i || state_q != S_DRAIN) begin
            rd_ptr_q   <= '0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            ov_q       <= 1'b0;
            sv_q       <= 1'b0;
            od_q       <= '0;
            osop_q     <= 1'b0;
            oeop_q     <= 1'b0;
            sd_q       <= '0;
            ssop_q     <= 1'b0;
            seop_q     <= 1'b0;
        end else begin
            pend_q     <= issue;
            pend_idx_q <= rd_ptr_q;
            if (issue) rd_ptr_q <= rd_ptr_q + ONE;
            if (pop) begin
                if (sv_q) begin
                    od_q   <= sd_q;
                    osop_q <= ssop_q;
                    oeop_q <= seop_q;
                    if (pend_q) begin
                        sd_q   <= rd_a_q;
                        ssop_q <= arr_sop;
                        seop_q <= arr_eop;
                    end else begin
                        sv_q <= 1'b0;
                    end
                end else if (pend_q) begin
                    od_q   <= rd_a_q;
                    osop_q <= arr_sop;
                    oeop_q <= arr_eop;
                end else begin
                    ov_q <= 1'b0;
                end
            end else if (!ov_q) begin
                if (pend_q) begin
                    ov_q   <= 1'b1;
                    od_q   <= rd_a_q;
                    osop_q <= arr_sop;
                    oeop_q <= arr_eop;
                end
            end else if (pend_q) begin
                sv_q   <= 1'b1;
                sd_q   <= rd_a_q;
                ssop_q <= arr_sop;
                seop_q <= arr_eop;
            end
        end
    end

    assign wr_ready_o  = (state_q == S_LOAD) && (cnt_q != N_MAX);
    assign busy_o      = (state_q == S_SORT_RD) || (state_q == S_SORT_CMP) || (state_q == S_DRAIN);
    assign count_o     = cnt_q;
    assign overflow_o  = ovf_q;
    assign out_data_o  = od_q;
    assign out_valid_o = ov_q;
    assign out_sop_o   = osop_q;
    assign out_eop_o   = oeop_q;

endmodule

// File: doc/gnome_sort_engine_kv.md
Name: gnome_sort_engine_kv

Overview:
- Parametrised successor to the single-mode gnome sort engine.
- Buffers up to 2**AWIDTH words, then sorts them in place by a key field. The non-key payload bits travel with their key.
- Sort direction (ascending/descending) and key signedness are selectable.
- Streams the sorted batch out on an Avalon-ST source with full backpressure. It sits between a producer writing a batch and a downstream streaming consumer.

Parameters:
- AWIDTH, 5, address width; depth N_MAX = 2**AWIDTH words.
- DWIDTH, 16, total word width (key + payload).
- KWIDTH, 8, key width. Key = wr_data_i[DWIDTH-1 -: KWIDTH]. Requires 1 <= KWIDTH <= DWIDTH.
- SIGNED_KEY, 0, 1 = keys compared as two's complement, 0 = unsigned.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- clear_i  in  1  drop the batch and return to LOAD.
- run_i  in  1  start strobe; only honoured in LOAD.
- desc_i  in  1  sort direction, sampled with run_i: 0 = ascending, 1 = descending.
- wr_req_i  in  1  write one word to the batch.
- wr_data_i  in  DWIDTH  word to write.
- wr_ready_o  out  1  high in LOAD while count_o < N_MAX.
- busy_o  out  1  high in SORT and DRAIN.
- count_o  out  AWIDTH+1  number of stored words.
- overflow_o  out  1  sticky; set when a write is dropped because the buffer is full.
- out_ready_i  in  1  sink ready.
- out_data_o  out  DWIDTH  output word.
- out_valid_o  out  1  output beat valid.
- out_sop_o  out  1  first beat of the batch.
- out_eop_o  out  1  last beat of the batch.

Behaviour:
- Reset (rst_i at a clock edge):
  - state = LOAD, count_o = 0, overflow_o = 0, busy_o = 0, wr_ready_o = 1.
  - out_valid_o, out_sop_o, out_eop_o = 0.
  - Memory contents are don't-care.
- Priority: rst_i > clear_i > run_i > wr_req_i.
- States: LOAD, SORT, DRAIN, DONE.
- LOAD:
  - wr_req_i with count_o < N_MAX: word stored at address count_o; count_o increments next cycle.
  - wr_req_i with count_o == N_MAX: word dropped; overflow_o = 1 next cycle.
  - run_i: latch desc_i; go to SORT if count_o >= 2, DRAIN if count_o == 1, DONE if count_o == 0 (no output beats).
  - wr_req_i in the same cycle as run_i is ignored.
- SORT (gnome sort, pair pointer i, resume pointer j):
  - Each step reads the pair (i-1, i), compares the keys, and swaps if out of order.
  - Out of order = key[i-1] > key[i] (ascending) or key[i-1] < key[i] (descending), using the SIGNED_KEY comparison.
  - Equal keys are never swapped, so the sort is stable.
  - Swap: i decrements, or jumps to j if i-1 == 0. No swap: i = j, j increments.
  - Exit to DRAIN when i reaches count_o.
  - Must complete within 3*count_o*count_o cycles.
- DRAIN:
  - Emits exactly count_o beats in sorted order, address 0 upward.
  - First out_valid_o no later than 3 cycles after entering DRAIN.
  - A beat transfers when out_valid_o && out_ready_i.
  - out_data_o, out_sop_o and out_eop_o hold stable while out_valid_o && !out_ready_i.
  - With out_ready_i held high, one beat per cycle with no bubbles (read-ahead/skid is required).
  - out_sop_o only on beat 0; out_eop_o only on beat count_o-1; both on the same beat when count_o == 1.
  - The cycle after the eop transfer: out_valid_o = 0, state = DONE.
- DONE:
  - busy_o = 0, wr_ready_o = 0.
  - run_i and wr_req_i ignored (no overflow set); only clear_i/rst_i leave DONE.
- Outside LOAD:
  - wr_ready_o = 0; wr_req_i ignored, does not set overflow_o.
  - run_i ignored.
- clear_i in any state, next cycle:
  - state = LOAD, count_o = 0, overflow_o = 0.
  - out_valid_o, out_sop_o, out_eop_o = 0.
  - busy_o = 0, wr_ready_o = 1.
  - A beat in flight is abandoned.
- Arithmetic:
  - count_o is AWIDTH+1 bits, so N_MAX is representable.
  - Internal pointers are AWIDTH+1 bits; no wrap.
  - Only the key bits take part in comparisons; payload bits are copied unchanged.
- Memory: inferred single-clock dual-port RAM, 1-cycle read latency, no registered output.

Test Plan:
- Ascending unsigned, KWIDTH=8, DWIDTH=16:
  - Load keys 5,3,9,1 with payloads 0..3.
  - run_i with desc_i=0.
  - Required output: 0x0103, 0x0301, 0x0500, 0x0902.
  - sop on beat 0, eop on beat 3; ready held high, so 4 consecutive valid cycles.
- Stability and descending:
  - Load keys 7,2,7,2 with payloads 0..3; run_i with desc_i=1.
  - Required output: 0x0700, 0x0702, 0x0201, 0x0203.
- Signed (SIGNED_KEY=1):
  - Load keys 0x7F, 0x80, 0x00, 0xFF; ascending.
  - Required key order: 0x80, 0xFF, 0x00, 0x7F.
- Boundaries:
  - count 0, then run: DONE, no beats, busy_o never high.
  - count 1 (key 0x42): one beat with sop = eop = 1.
  - Load N_MAX+2 = 34 words: count_o = 32, overflow_o = 1, wr_ready_o = 0 once full.
- Backpressure:
  - Reverse-sorted 32-word batch; toggle out_ready_i randomly.
  - Required: data and sop/eop stable while stalled; exactly 32 beats, ascending.
- Clear and reset mid-operation:
  - clear_i during SORT → LOAD next cycle with count_o = 0.
  - clear_i on beat 3 of DRAIN → out_valid_o = 0 next cycle.
  - rst_i at the same cycle as run_i → LOAD, no sort starts.
  - A new 3-word batch afterwards sorts correctly.
